// File: rtl/game_sequencer.sv
// Purpose: button/vsync conditioning and IDLE/PLAY/OVER/READY game control with BCD scoring.
// Latency: raw button rise to press_evt DEBOUNCE_CYC+3 cycles, jump_pulse one cycle later; outputs registered.
// Backpressure: none; all inputs are levels or one-cycle pulses consumed every cycle.
`timescale 1ns/1ps
module game_sequencer #(
   parameter int DEBOUNCE_CYC   = 1_485_000,
   parameter int LOCKOUT_FRAMES = 120,
   parameter int SPEED_STEP_PTS = 5
) (
   input  logic        clk148,
   input  logic        rst_n,
   input  logic        btn_raw,
   input  logic        v_sync_in,
   input  logic        collision_in,
   input  logic        point_in,
   output logic        core_rst,
   output logic        run_en,
   output logic        jump_pulse,
   output logic [1:0]  state,
   output logic [15:0] score,
   output logic [15:0] hi_score,
   output logic [2:0]  speed_lvl
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int LK_W = $clog2(LOCKOUT_FRAMES + 1);
   localparam int PT_W = $clog2(SPEED_STEP_PTS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_PLAY  = 2'b01,
      S_OVER  = 2'b10,
      S_READY = 2'b11
   } state_t;

   // input conditioning registers
   logic            btn_s1_q, btn_s2_q;
   logic            deb_q, deb_prev_q;
   logic [DB_W-1:0] db_cnt_q;
   logic            press_q;
   logic            vs_s1_q, vs_s2_q, vs_s3_q;
   logic            frame_q;

   // game state registers
   state_t          state_q, state_d;
   logic [15:0]     score_q, score_d;
   logic [15:0]     hi_q, hi_d;
   logic [2:0]      spd_q, spd_d;
   logic [PT_W-1:0] pts_q, pts_d;
   logic [LK_W-1:0] lock_q, lock_d;
   logic            jump_q, jump_d;
   logic            core_rst_q, run_en_q;
   logic [15:0]     score_inc;

   // Saturating 4-digit BCD increment with per-digit carry.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (c) begin
               if (r[4*i +: 4] == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Synchronize, debounce and edge-detect the button and vsync.
   // The debounced level resets to 'pressed' so a button held across reset
   // must be released and pressed again before a press is recognised.
   always_ff @(posedge clk148 or posedge rst_n) begin
      if (rst_n) begin
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         db_cnt_q   <= '0;
         press_q    <= 1'b0;
         vs_s1_q    <= 1'b0;
         vs_s2_q    <= 1'b0;
         vs_s3_q    <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         btn_s1_q <= btn_raw;
         btn_s2_q <= btn_s1_q;
         if (btn_s2_q == deb_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            deb_q    <= btn_s2_q;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
         end
         deb_prev_q <= deb_q;
         press_q    <= deb_q & ~deb_prev_q;
         vs_s1_q    <= v_sync_in;
         vs_s2_q    <= vs_s1_q;
         vs_s3_q    <= vs_s2_q;
         frame_q    <= vs_s2_q & ~vs_s3_q;
      end
   end

   assign score_inc = bcd_inc(score_q);

   // Next-state, scoring, speed and lockout logic.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      hi_d    = hi_q;
      spd_d   = spd_q;
      pts_d   = pts_q;
      lock_d  = lock_q;
      jump_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press_q) begin
               state_d = S_PLAY;
               score_d = '0;
               spd_d   = '0;
               pts_d   = '0;
            end
         end
         S_PLAY: begin
            if (press_q && !collision_in) begin
               jump_d = 1'b1;
            end
            if (point_in) begin
               score_d = score_inc;
               if (pts_q == PT_W'(SPEED_STEP_PTS - 1)) begin
                  pts_d = '0;
                  if (spd_q != 3'd7) begin
                     spd_d = spd_q + 3'd1;
                  end
               end else begin
                  pts_d = pts_q + PT_W'(1);
               end
            end
            if (collision_in) begin
               state_d = S_OVER;
               lock_d  = '0;
               // BCD digit order preserves magnitude, so a binary compare works.
               if (score_d > hi_q) begin
                  hi_d = score_d;
               end
            end
         end
         S_OVER: begin
            if (frame_q) begin
               if (lock_q == LK_W'(LOCKOUT_FRAMES - 1)) begin
                  state_d = S_READY;
                  lock_d  = '0;
               end else begin
                  lock_d = lock_q + LK_W'(1);
               end
            end
         end
         S_READY: begin
            if (press_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; control outputs decoded from next state.
   always_ff @(posedge clk148 or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= S_IDLE;
         score_q    <= '0;
         hi_q       <= '0;
         spd_q      <= '0;
         pts_q      <= '0;
         lock_q     <= '0;
         jump_q     <= 1'b0;
         core_rst_q <= 1'b1;
         run_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         hi_q       <= hi_d;
         spd_q      <= spd_d;
         pts_q      <= pts_d;
         lock_q     <= lock_d;
         jump_q     <= jump_d;
         core_rst_q <= (state_d == S_IDLE);
         run_en_q   <= (state_d == S_PLAY);
      end
   end

   assign state      = state_q;
   assign score      = score_q;
   assign hi_score   = hi_q;
   assign speed_lvl  = spd_q;
   assign jump_pulse = jump_q;
   assign core_rst   = core_rst_q;
   assign run_en     = run_en_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose: directed self-checking bench for game_sequencer with short debounce/lockout.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
`timescale 1ns/1ps
module tb_game_sequencer;

   logic        clk148 = 1'b0;
   logic        rst_n;
   logic        btn_raw, v_sync_in, collision_in, point_in;
   logic        core_rst, run_en, jump_pulse;
   logic [1:0]  state;
   logic [15:0] score, hi_score;
   logic [2:0]  speed_lvl;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int jumps;
   int first_jump;

   game_sequencer #(
      .DEBOUNCE_CYC   (4),
      .LOCKOUT_FRAMES (2),
      .SPEED_STEP_PTS (5)
   ) dut (
      .clk148       (clk148),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw),
      .v_sync_in    (v_sync_in),
      .collision_in (collision_in),
      .point_in     (point_in),
      .core_rst     (core_rst),
      .run_en       (run_en),
      .jump_pulse   (jump_pulse),
      .state        (state),
      .score        (score),
      .hi_score     (hi_score),
      .speed_lvl    (speed_lvl)
   );

   always #5 clk148 = ~clk148;

   task automatic tick();
      @(posedge clk148);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},    16'(state),      16'h0);
      check({tag, "_core_rst"}, 16'(core_rst),   16'h1);
      check({tag, "_run_en"},   16'(run_en),     16'h0);
      check({tag, "_jump"},     16'(jump_pulse), 16'h0);
      check({tag, "_score"},    score,           16'h0);
      check({tag, "_hi"},       hi_score,        16'h0);
      check({tag, "_speed"},    16'(speed_lvl),  16'h0);
   endtask

   initial begin
      rst_n = 1'b1; btn_raw = 1'b0; v_sync_in = 1'b0;
      collision_in = 1'b0; point_in = 1'b0;
      repeat (3) tick();
      check_reset_vals("rst");
      rst_n = 1'b0;
      repeat (10) tick();
      check("idle_after_rst", 16'(state), 16'h0);

      // start press with bounce glitches
      btn_raw = 1'b1; tick(); btn_raw = 1'b0; tick();
      btn_raw = 1'b1; tick(); btn_raw = 1'b0; tick();
      btn_raw = 1'b1; tick(); btn_raw = 1'b0; tick();
      check("bounce_still_idle", 16'(state), 16'h0);
      btn_raw = 1'b1;
      jumps = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (jump_pulse) jumps++;
      end
      check("start_state_play", 16'(state), 16'h1);
      check("start_no_jump", 16'(jumps), 16'h0);
      check("play_run_en", 16'(run_en), 16'h1);
      check("play_core_rst", 16'(core_rst), 16'h0);
      btn_raw = 1'b0;
      repeat (10) tick();

      // clean jump press, pulse expected 8 cycles after raw rise
      btn_raw = 1'b1;
      jumps = 0; first_jump = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (jump_pulse) begin
            jumps++;
            if (first_jump == 0) first_jump = i;
         end
      end
      check("jump_count", 16'(jumps), 16'h1);
      check("jump_latency", 16'(first_jump), 16'd8);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (jump_pulse) jumps++;
      end
      check("jump_held_no_repeat", 16'(jumps), 16'h1);
      btn_raw = 1'b0;
      repeat (10) tick();
      check("still_play", 16'(state), 16'h1);

      // seven points then point+collision together
      repeat (7) begin point_in = 1'b1; tick(); point_in = 1'b0; tick(); end
      check("score7", score, 16'h0007);
      check("speed_after7", 16'(speed_lvl), 16'h1);
      point_in = 1'b1; collision_in = 1'b1; tick();
      point_in = 1'b0; collision_in = 1'b0;
      check("over_state", 16'(state), 16'h2);
      check("over_score", score, 16'h0008);
      check("over_hi", hi_score, 16'h0008);
      check("over_run_en", 16'(run_en), 16'h0);
      check("over_core_rst", 16'(core_rst), 16'h0);

      // press during lockout ignored, points ignored
      btn_raw = 1'b1;
      jumps = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (jump_pulse) jumps++;
      end
      btn_raw = 1'b0;
      repeat (10) tick();
      check("over_press_ignored", 16'(state), 16'h2);
      check("over_no_jump", 16'(jumps), 16'h0);
      point_in = 1'b1; tick(); point_in = 1'b0; tick();
      check("over_point_ignored", score, 16'h0008);
      v_sync_in = 1'b1; repeat (4) tick(); v_sync_in = 1'b0; repeat (4) tick();
      check("one_frame_still_over", 16'(state), 16'h2);
      v_sync_in = 1'b1; repeat (4) tick(); v_sync_in = 1'b0; repeat (4) tick();
      check("two_frames_ready", 16'(state), 16'h3);
      check("ready_score_hold", score, 16'h0008);

      // READY press -> IDLE, then another press -> PLAY
      btn_raw = 1'b1; repeat (9) tick();
      check("ready_to_idle", 16'(state), 16'h0);
      check("idle_core_rst", 16'(core_rst), 16'h1);
      check("idle_hi_kept", hi_score, 16'h0008);
      btn_raw = 1'b0; repeat (10) tick();
      btn_raw = 1'b1; repeat (9) tick();
      check("restart_play", 16'(state), 16'h1);
      check("restart_score_clr", score, 16'h0000);
      check("restart_hi_kept", hi_score, 16'h0008);
      btn_raw = 1'b0; repeat (10) tick();

      // reset mid-play with score 5
      repeat (5) begin point_in = 1'b1; tick(); point_in = 1'b0; tick(); end
      check("score5", score, 16'h0005);
      rst_n = 1'b1;
      #1;
      check_reset_vals("midplay_rst");
      btn_raw = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      repeat (20) tick();
      check("held_btn_no_start", 16'(state), 16'h0);
      btn_raw = 1'b0; repeat (10) tick();
      check("release_no_start", 16'(state), 16'h0);
      btn_raw = 1'b1; repeat (9) tick();
      check("repress_play", 16'(state), 16'h1);
      btn_raw = 1'b0; repeat (10) tick();

      // 12 points, then saturate at 9999
      repeat (12) begin point_in = 1'b1; tick(); point_in = 1'b0; tick(); end
      check("score12", score, 16'h0012);
      check("speed2", 16'(speed_lvl), 16'h2);
      point_in = 1'b1;
      repeat (9987) tick();
      point_in = 1'b0; tick();
      check("score9999", score, 16'h9999);
      check("speed_sat", 16'(speed_lvl), 16'h7);
      point_in = 1'b1; tick(); point_in = 1'b0; tick();
      check("score_sat", score, 16'h9999);
      check("sat_still_play", 16'(state), 16'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 1_485_000, meaning clk148 cycles the synchronized button level must stay stable (10 ms).
REQ-002 The block SHALL have parameter LOCKOUT_FRAMES, default 120, meaning frames during which presses are ignored after game over.
REQ-003 The block SHALL have parameter SPEED_STEP_PTS, default 5, meaning points per speed-level increment.
REQ-004 The block SHALL have port clk148, input, 1 bit: pixel/system clock, 148.5 MHz.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high (name kept for codebase compatibility); clock is clk148.
REQ-006 The block SHALL have port btn_raw, input, 1 bit: asynchronous, bouncing jump/start button.
REQ-007 The block SHALL have port v_sync_in, input, 1 bit: vertical sync from the VGA timing datapath, active-high.
REQ-008 The block SHALL have port collision_in, input, 1 bit: level, bird/wall overlap.
REQ-009 The block SHALL have port point_in, input, 1 bit: one-cycle pulse per obstacle passed.
REQ-010 The block SHALL have port core_rst, output, 1 bit: holds the game datapath in reset.
REQ-011 The block SHALL have port run_en, output, 1 bit: enables wall/gravity motion.
REQ-012 The block SHALL have port jump_pulse, output, 1 bit: one-cycle jump strobe to the datapath.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=00, PLAY=01, OVER=10, READY=11.
REQ-014 The block SHALL have port score, output, 16 bits: 4-digit BCD current score.
REQ-015 The block SHALL have port hi_score, output, 16 bits: 4-digit BCD best score.
REQ-016 The block SHALL have port speed_lvl, output, 3 bits: difficulty level 0..7.

Function
REQ-017 btn_raw SHALL pass a 2-FF synchronizer; debounced level SHALL flip only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles, with the counter cleared on any re-match.
REQ-018 press_evt SHALL be a registered one-cycle pulse on the rising edge of the debounced level; raw rise to press_evt SHALL take exactly DEBOUNCE_CYC+3 cycles for clean input.
REQ-019 v_sync_in SHALL be 2-FF synchronized; frame_evt SHALL be a one-cycle pulse on its rising edge.
REQ-020 IDLE: core_rst=1, run_en=0; press_evt SHALL go to PLAY, clear score and speed_lvl; no jump_pulse is issued for the start press.
REQ-021 PLAY: core_rst=0, run_en=1; each press_evt SHALL produce jump_pulse the following cycle.
REQ-022 PLAY: each point_in SHALL increment score in BCD with per-digit carry and saturate at 9999.
REQ-023 speed_lvl SHALL increment by 1 every SPEED_STEP_PTS points (internal modulo counter) and saturate at 7.
REQ-024 PLAY: collision_in=1 SHALL go to OVER next cycle; point_in in the same cycle SHALL still be counted.
REQ-025 On OVER entry, hi_score SHALL load score if score > hi_score (BCD compare), else hold.
REQ-026 OVER: run_en=0, core_rst=0 (frozen picture), jump_pulse=0; a lockout counter SHALL count frame_evt; after LOCKOUT_FRAMES frames it SHALL go to READY; press_evt in OVER SHALL be ignored.
REQ-027 READY: outputs as OVER; press_evt SHALL go to IDLE for one cycle, then IDLE behaviour applies (a second press starts play).
REQ-028 point_in and collision_in SHALL be ignored outside PLAY; score SHALL hold its value in OVER/READY.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting rst_n SHALL immediately force state=IDLE, core_rst=1, run_en=0, jump_pulse=0, score=0, hi_score=0, speed_lvl=0, and clear synchronizers, debounce and lockout counters, in any state, mid-debounce or mid-lockout.
REQ-031 After rst_n deasserts, a button held throughout reset SHALL NOT produce press_evt until it is released and pressed again.

Verification
REQ-032 DEBOUNCE_CYC=4: in IDLE, raw press with 3-cycle bounce glitches then stable -> single press_evt, state 00->01, no jump_pulse.
REQ-033 In PLAY, clean press -> jump_pulse high exactly one cycle at DEBOUNCE_CYC+4 cycles after raw rise; held button -> no further pulses.
REQ-034 In PLAY, 12 point_in pulses -> score=0x0012, speed_lvl=2; preload 9999 plus one pulse -> 0x9999.
REQ-035 point_in and collision_in in same cycle with score=0x0007 -> state=10, score=0x0008, hi_score=0x0008.
REQ-036 LOCKOUT_FRAMES=2: in OVER, press before 2 v_sync rises -> ignored; after 2 -> state=11; press -> 00, core_rst=1; hi_score retained.
REQ-037 rst_n asserted mid-PLAY with score=0x0005 -> all outputs at reset values in the same cycle, hi_score=0.
